// File: rtl/work_frame_receiver.sv
// work_frame_receiver: assembles one SOF-framed work unit from a byte stream.
// When it is accepted, the unit is published on work_data with a new_work strobe.
// A frame that fails its checksum or stalls too long is dropped with a frame_error strobe.
// Optional feature macro: WORK_FRAME_CHECKSUM_EN.
//   - Defined: a trailing XOR checksum byte is expected and checked.
//   - Undefined: the frame commits right after the last payload byte.
module work_frame_receiver #(
    parameter int unsigned WORK_BYTES     = 80,
    parameter logic [7:0]  SOF_BYTE       = 8'h57,
    parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_data,
    input  logic                    new_rx_data,
    output logic                    new_work,
    output logic [8*WORK_BYTES-1:0] work_data,
    output logic                    frame_error,
    output logic                    busy
);

    localparam int unsigned DATA_W = 8 * WORK_BYTES;
    localparam int unsigned CNT_W  = $clog2(WORK_BYTES + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1
`ifdef WORK_FRAME_CHECKSUM_EN
        ,
        S_CHECK   = 2'd2
`endif
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_byte_cnt;
    logic [CNT_W-1:0]    w_byte_cnt_next;
    logic [TMO_W-1:0]    r_tmo_cnt;
    logic [TMO_W-1:0]    w_tmo_cnt_next;
    logic [DATA_W-1:0]   r_shadow;
    logic [DATA_W-1:0]   w_shadow_next;
    logic [DATA_W-1:0]   r_work_data;
    logic [DATA_W-1:0]   w_work_data_next;
    logic                r_new_work;
    logic                w_new_work_next;
    logic                r_frame_error;
    logic                w_frame_error_next;
    logic                r_busy;
    logic                w_busy_next;
    logic                w_last_byte;
    logic                w_timeout;
`ifdef WORK_FRAME_CHECKSUM_EN
    logic [7:0]          r_cks;
    logic [7:0]          w_cks_next;
`endif

    assign w_last_byte = (r_byte_cnt == CNT_W'(WORK_BYTES - 1));
    assign w_timeout   = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign w_busy_next = (w_state_next != S_IDLE);

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_byte_cnt    <= '0;
            r_tmo_cnt     <= '0;
            r_shadow      <= '0;
            r_work_data   <= '0;
            r_new_work    <= 1'b0;
            r_frame_error <= 1'b0;
            r_busy        <= 1'b0;
`ifdef WORK_FRAME_CHECKSUM_EN
            r_cks         <= '0;
`endif
        end else begin
            r_state       <= w_state_next;
            r_byte_cnt    <= w_byte_cnt_next;
            r_tmo_cnt     <= w_tmo_cnt_next;
            r_shadow      <= w_shadow_next;
            r_work_data   <= w_work_data_next;
            r_new_work    <= w_new_work_next;
            r_frame_error <= w_frame_error_next;
            r_busy        <= w_busy_next;
`ifdef WORK_FRAME_CHECKSUM_EN
            r_cks         <= w_cks_next;
`endif
        end
    end

    // Next-state and datapath decisions for the frame receiver
    always_comb begin
        w_state_next       = r_state;
        w_byte_cnt_next    = r_byte_cnt;
        w_tmo_cnt_next     = r_tmo_cnt;
        w_shadow_next      = r_shadow;
        w_work_data_next   = r_work_data;
        w_new_work_next    = 1'b0;
        w_frame_error_next = 1'b0;
`ifdef WORK_FRAME_CHECKSUM_EN
        w_cks_next         = r_cks;
`endif
        case (r_state)
            S_IDLE: begin
                if (new_rx_data && (rx_data == SOF_BYTE)) begin
                    w_state_next    = S_PAYLOAD;
                    w_byte_cnt_next = '0;
                    w_tmo_cnt_next  = '0;
`ifdef WORK_FRAME_CHECKSUM_EN
                    w_cks_next      = '0;
`endif
                end
            end
            default: begin
                // Frame in progress: an arriving byte always beats the timeout
                if (!new_rx_data) begin
                    if (w_timeout) begin
                        w_frame_error_next = 1'b1;
                        w_state_next       = S_IDLE;
                    end else begin
                        w_tmo_cnt_next = r_tmo_cnt + TMO_W'(1);
                    end
                end else begin
                    w_tmo_cnt_next = '0;
`ifdef WORK_FRAME_CHECKSUM_EN
                    if (r_state == S_CHECK) begin
                        w_state_next = S_IDLE;
                        if (rx_data == r_cks) begin
                            w_work_data_next = r_shadow;
                            w_new_work_next  = 1'b1;
                        end else begin
                            w_frame_error_next = 1'b1;
                        end
                    end else
`endif
                    begin
                        for (int k = 0; k < int'(WORK_BYTES); k++) begin
                            if (r_byte_cnt == CNT_W'(k)) begin
                                w_shadow_next[8*k +: 8] = rx_data;
                            end
                        end
                        w_byte_cnt_next = r_byte_cnt + CNT_W'(1);
`ifdef WORK_FRAME_CHECKSUM_EN
                        w_cks_next = r_cks ^ rx_data;
                        if (w_last_byte) begin
                            w_state_next = S_CHECK;
                        end
`else
                        if (w_last_byte) begin
                            w_work_data_next = w_shadow_next;
                            w_new_work_next  = 1'b1;
                            w_state_next     = S_IDLE;
                        end
`endif
                    end
                end
            end
        endcase
    end

    assign new_work    = r_new_work;
    assign work_data   = r_work_data;
    assign frame_error = r_frame_error;
    assign busy        = r_busy;

endmodule

// File: tb/tb_work_frame_receiver.sv
// tb_work_frame_receiver: directed plus randomized frames against a frame-level model.
module tb_work_frame_receiver;

    localparam int unsigned WB  = 80;
    localparam int unsigned TMO = 100;
    localparam int unsigned DW  = 8 * WB;
    localparam logic [7:0]  SOF = 8'h57;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          new_rx_data;
    logic          new_work;
    logic [DW-1:0] work_data;
    logic          frame_error;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    int obs_nw   = 0;
    int obs_fe   = 0;
    int obs_both = 0;
    int exp_nw   = 0;
    int exp_fe   = 0;

    logic [7:0]    pl [WB];
    logic [DW-1:0] exp_work;

    work_frame_receiver #(
        .WORK_BYTES     (WB),
        .SOF_BYTE       (SOF),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .new_rx_data (new_rx_data),
        .new_work    (new_work),
        .work_data   (work_data),
        .frame_error (frame_error),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Pulse bookkeeping for the whole run
    always @(negedge clk) begin
        if (new_work === 1'b1)    obs_nw++;
        if (frame_error === 1'b1) obs_fe++;
        if (new_work === 1'b1 && frame_error === 1'b1) obs_both++;
    end

    function automatic logic [DW-1:0] model_work();
        logic [DW-1:0] w;
        w = '0;
        for (int k = 0; k < int'(WB); k++) w[8*k +: 8] = pl[k];
        return w;
    endfunction

`ifdef WORK_FRAME_CHECKSUM_EN
    function automatic logic [7:0] model_xor();
        logic [7:0] x;
        x = 8'h00;
        for (int k = 0; k < int'(WB); k++) x = x ^ pl[k];
        return x;
    endfunction
`endif

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] b);
        rx_data     = b;
        new_rx_data = 1'b1;
        @(negedge clk);
        new_rx_data = 1'b0;
    endtask

    task automatic idle(input int n);
        new_rx_data = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // SOF, payload from pl[], then checksum XOR cks_err when checksums are enabled
    task automatic send_frame(input int gap, input logic [7:0] cks_err);
        drive(SOF);
        for (int k = 0; k < int'(WB); k++) begin
            idle(gap);
            drive(pl[k]);
        end
`ifdef WORK_FRAME_CHECKSUM_EN
        idle(gap);
        drive(model_xor() ^ cks_err);
`else
        if (cks_err != 8'h00) $display("note: checksum corruption ignored in this build");
`endif
    endtask

    // Outcome one cycle after the final byte's strobe
    task automatic expect_result(input string tag, input bit ok);
        if (ok) begin
            exp_work = model_work();
            exp_nw++;
        end else begin
            exp_fe++;
        end
        check_bit({tag, "_new_work"}, new_work, ok);
        check_bit({tag, "_frame_error"}, frame_error, !ok);
        check_bit({tag, "_busy"}, busy, 1'b0);
        check_word({tag, "_work_data"}, work_data, exp_work);
    endtask

    task automatic rand_payload();
        for (int k = 0; k < int'(WB); k++) pl[k] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] err;
        int gap;
        rst         = 1'b1;
        rx_data     = 8'h00;
        new_rx_data = 1'b0;
        exp_work    = '0;
        idle(3);
        rst = 1'b0;
        idle(1);
        check_bit("reset_new_work", new_work, 1'b0);
        check_bit("reset_frame_error", frame_error, 1'b0);
        check_bit("reset_busy", busy, 1'b0);
        check_word("reset_work_data", work_data, '0);

        // Counting payload 0x00..0x4F, checksum 0x00
        for (int k = 0; k < int'(WB); k++) pl[k] = 8'(k);
        send_frame(0, 8'h00);
        expect_result("count", 1'b1);
        check_word("count_byte0", DW'(work_data[7:0]), DW'(8'h00));
        check_word("count_byte79", DW'(work_data[DW-1 -: 8]), DW'(8'h4F));
        idle(2);

`ifdef WORK_FRAME_CHECKSUM_EN
        send_frame(0, 8'h01);
        expect_result("bad_cks", 1'b0);
        idle(2);
`endif

        // Garbage in IDLE, then an all-0xAA frame
        drive(8'h00); idle(1); drive(8'hFF); drive(8'h12);
        idle(1);
        check_bit("garbage_busy", busy, 1'b0);
        check_bit("garbage_frame_error", frame_error, 1'b0);
        for (int k = 0; k < int'(WB); k++) pl[k] = 8'hAA;
        send_frame(1, 8'h00);
        expect_result("all_aa", 1'b1);
        idle(2);

        // Timeout: SOF plus 10 bytes, then silence
        rand_payload();
        drive(SOF);
        for (int k = 0; k < 10; k++) drive(pl[k]);
        idle(TMO - 1);
        check_bit("tmo_pre_busy", busy, 1'b1);
        check_bit("tmo_pre_frame_error", frame_error, 1'b0);
        idle(1);
        exp_fe++;
        check_bit("tmo_frame_error", frame_error, 1'b1);
        check_bit("tmo_busy", busy, 1'b0);
        check_bit("tmo_new_work", new_work, 1'b0);
        check_word("tmo_work_data", work_data, exp_work);
        idle(2);
        rand_payload();
        send_frame(0, 8'h00);
        expect_result("after_tmo", 1'b1);
        idle(2);

        // Every byte lands exactly on the expiry cycle
        rand_payload();
        send_frame(TMO - 1, 8'h00);
        expect_result("tmo_edge", 1'b1);
        idle(2);

        // Reset in the middle of a frame
        rand_payload();
        drive(SOF);
        for (int k = 0; k < 40; k++) drive(pl[k]);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        exp_work = '0;
        check_bit("midrst_busy", busy, 1'b0);
        check_bit("midrst_new_work", new_work, 1'b0);
        check_word("midrst_work_data", work_data, exp_work);
        rand_payload();
        send_frame(0, 8'h00);
        expect_result("after_rst", 1'b1);

        // Stray byte right after commit is ignored
        drive(8'h12);
        idle(1);
        check_bit("stray_busy", busy, 1'b0);
        idle(3);

        // Randomized frames, some back-to-back with zero gap
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                b = 8'($urandom_range(0, 255));
                if (b == SOF) b = 8'h00;
                drive(b);
            end
            rand_payload();
            gap = int'($urandom_range(0, 2));
            err = 8'h00;
`ifdef WORK_FRAME_CHECKSUM_EN
            if ($urandom_range(0, 2) == 0) err = 8'($urandom_range(1, 255));
`endif
            send_frame(gap, err);
            expect_result("rand", err == 8'h00);
            if ((i % 2) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(3);

        check_int("new_work_pulses", obs_nw, exp_nw);
        check_int("frame_error_pulses", obs_fe, exp_fe);
        check_int("overlapping_pulses", obs_both, 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
